// File: rtl/gshare_pkg.sv
// Shared types and constants for the gshare global-history predictor.
package gshare_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_WEAK_NT = 2'b01;
    localparam ctr2_t CTR_MAX     = 2'b11;

    typedef enum logic [0:0] {
        INIT,
        RUN
    } gshare_state_e;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic ctr2_t ctr_update(input ctr2_t ctr, input logic taken);
        ctr2_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pending_fifo.sv
// In-order queue of table indices for predictions awaiting resolution.
// Full/empty come from read/write pointers carrying an extra wrap bit.
module gshare_pending_fifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    // Pointer advance; caller guarantees push only when not full, pop only when not empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage has no reset; only entries between the pointers are meaningful.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/gshare_global_predictor.sv
// Gshare direction predictor: PC bits XOR a non-speculative global history
// select a 2-bit saturating counter. Predicted indices are queued so the
// resolve trains exactly the counter that was read.
// Optional macro GSHARE_FWD_EN: a same-cycle resolve to the entry being read
// forwards its updated counter into the prediction.
module gshare_global_predictor
    import gshare_pkg::*;
#(
    parameter int unsigned GHR_W   = 12,
    parameter int unsigned PC_LSB  = 2,
    parameter int unsigned Q_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_ready,
    output logic        pred_out_valid,
    output logic        global_predicton_taken,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic        resolve_ready,
    output logic        init_done
);

    localparam int unsigned ENTRIES = 1 << GHR_W;

    ctr2_t         ctr_table [ENTRIES];
    gshare_state_e state_q;
    logic [GHR_W-1:0] sweep_q;
    logic [GHR_W-1:0] ghr_q;
    logic          init_done_q;
    logic          pov_q;
    logic          taken_q;

    logic             q_full;
    logic             q_empty;
    logic [GHR_W-1:0] res_idx;
    logic [GHR_W-1:0] rd_idx;
    logic             pred_fire;
    logic             res_fire;
    ctr2_t            res_new;
    ctr2_t            rd_ctr;
    logic             wr_en;
    logic [GHR_W-1:0] wr_idx;
    ctr2_t            wr_data;
    logic             unused_pc;

    assign unused_pc = ^{pred_pc[31:PC_LSB+GHR_W], pred_pc[PC_LSB-1:0]};

    assign pred_ready    = (state_q == RUN) && !q_full;
    assign resolve_ready = !q_empty;
    assign pred_fire     = pred_valid && pred_ready;
    assign res_fire      = resolve_valid && !q_empty;
    assign rd_idx        = pred_pc[PC_LSB+GHR_W-1:PC_LSB] ^ ghr_q;
    assign res_new       = ctr_update(ctr_table[res_idx], resolve_taken);

    assign pred_out_valid         = pov_q;
    assign global_predicton_taken = taken_q;
    assign init_done              = init_done_q;

    gshare_pending_fifo #(
        .W     (GHR_W),
        .DEPTH (Q_DEPTH)
    ) u_pending (
        .clock     (clock),
        .reset     (reset),
        .push      (pred_fire),
        .push_data (rd_idx),
        .pop       (res_fire),
        .pop_data  (res_idx),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Counter read for the prediction, optionally bypassing a same-cycle update.
    always_comb begin
        rd_ctr = ctr_table[rd_idx];
`ifdef GSHARE_FWD_EN
        if (res_fire && (res_idx == rd_idx)) rd_ctr = res_new;
`endif
    end

    // Single table write port shared by the init sweep and resolve training.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = res_idx;
        wr_data = res_new;
        if (state_q == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_q;
            wr_data = CTR_WEAK_NT;
        end else if (res_fire) begin
            wr_en = 1'b1;
        end
    end

    // Counter table storage; contents are rebuilt by the sweep after every reset.
    always_ff @(posedge clock) begin
        if (wr_en) ctr_table[wr_idx] <= wr_data;
    end

    // Init sweep FSM with registered init_done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    sweep_q <= sweep_q + GHR_W'(1);
                    if (&sweep_q) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: state_q <= RUN;
                default: state_q <= INIT;
            endcase
        end
    end

    // History shift on resolve and registered prediction result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr_q   <= '0;
            pov_q   <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            if (res_fire) ghr_q <= {ghr_q[GHR_W-2:0], resolve_taken};
            pov_q <= pred_fire;
            if (pred_fire) taken_q <= rd_ctr[1];
        end
    end

endmodule

// File: tb/tb_gshare_global_predictor.sv
// Directed bench for gshare_global_predictor with hand-computed expectations.
module tb_gshare_global_predictor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_ready;
    logic        pred_out_valid;
    logic        global_predicton_taken;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        resolve_ready;
    logic        init_done;

    int checks = 0;
    int passed = 0;

    gshare_global_predictor dut (
        .clock                  (clock),
        .reset                  (reset),
        .pred_valid             (pred_valid),
        .pred_pc                (pred_pc),
        .pred_ready             (pred_ready),
        .pred_out_valid         (pred_out_valid),
        .global_predicton_taken (global_predicton_taken),
        .resolve_valid          (resolve_valid),
        .resolve_taken          (resolve_taken),
        .resolve_ready          (resolve_ready),
        .init_done              (init_done)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic predict(input logic [31:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
        tick();
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic t);
        resolve_valid = 1'b1;
        resolve_taken = t;
        tick();
        resolve_valid = 1'b0;
    endtask

    // Release reset at a falling edge and count rising edges until pred_ready.
    task automatic release_and_count(output int n, output logic early_done);
        n = 0;
        early_done = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        while (!pred_ready && n < 6000) begin
            tick();
            n++;
            if (init_done && !pred_ready) early_done = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({pred_ready, pred_out_valid, global_predicton_taken, resolve_ready, init_done}
            !== 5'b0) begin
            $display("FAIL %s: outputs rdy/pov/tkn/rrdy/done = %b, required 00000", tag,
                     {pred_ready, pred_out_valid, global_predicton_taken, resolve_ready,
                      init_done});
        end else passed++;
    endtask

    task automatic check_init_len(input string tag);
        int   n;
        logic early;
        release_and_count(n, early);
        checks++;
        if (n !== 4096) $display("FAIL %s_len: init edges = %0d, required 4096", tag, n);
        else passed++;
        checks++;
        if (init_done !== 1'b1 || early !== 1'b0)
            $display("FAIL %s_done: init_done=%b early=%b, required 1 0", tag, init_done, early);
        else passed++;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_immediate");
        tick();
        tick();
        check_reset_outputs("reset_held");
        check_init_len("reset_init");
    endtask

    task automatic test_first_predict();
        predict(32'h0000_1000);
        checks++;
        if (pred_out_valid !== 1'b1 || global_predicton_taken !== 1'b0)
            $display("FAIL first_pred: pov=%b taken=%b, required 1 0",
                     pred_out_valid, global_predicton_taken);
        else passed++;
        checks++;
        if (resolve_ready !== 1'b1)
            $display("FAIL first_rrdy: resolve_ready=%b, required 1", resolve_ready);
        else passed++;
        tick();
        checks++;
        if (pred_out_valid !== 1'b0)
            $display("FAIL pov_idle: pred_out_valid=%b, required 0", pred_out_valid);
        else passed++;
        resolve(1'b1);
        checks++;
        if (resolve_ready !== 1'b0)
            $display("FAIL first_drain: resolve_ready=%b, required 0", resolve_ready);
        else passed++;
    endtask

    task automatic test_training();
        // GHR fills to 0xFFF; index 0x400^0xFFF = 0xBFF untouched so far (01).
        for (int i = 0; i < 11; i++) begin
            predict(32'h0000_1000);
            resolve(1'b1);
        end
        predict(32'h0000_1000);
        checks++;
        if (global_predicton_taken !== 1'b0)
            $display("FAIL train_01: taken=%b, required 0", global_predicton_taken);
        else passed++;
        resolve(1'b1);
        predict(32'h0000_1000);
        checks++;
        if (global_predicton_taken !== 1'b1)
            $display("FAIL train_10: taken=%b, required 1", global_predicton_taken);
        else passed++;
        resolve(1'b1);
        // Counter at 0xBFF is now 11; queue three reads of it, then untrain.
        predict(32'h0000_1000);
        checks++;
        if (pred_out_valid !== 1'b1 || global_predicton_taken !== 1'b1)
            $display("FAIL train_11: pov=%b taken=%b, required 1 1",
                     pred_out_valid, global_predicton_taken);
        else passed++;
        predict(32'h0000_1000);
        predict(32'h0000_1000);
        resolve(1'b0);
        resolve(1'b0);
        resolve(1'b0);
        // GHR = 0xFF8; PC bits 0x407 map back to 0xBFF.
        predict(32'h0000_101C);
        checks++;
        if (global_predicton_taken !== 1'b0)
            $display("FAIL untrain_pred: taken=%b, required 0", global_predicton_taken);
        else passed++;
        // One taken resolve: 00->01 keeps prediction 0 (01 would have gone to 10).
        resolve(1'b1);
        // GHR = 0xFF1; PC bits 0x40E map to 0xBFF.
        predict(32'h0000_1038);
        checks++;
        if (global_predicton_taken !== 1'b0)
            $display("FAIL untrain_zero: taken=%b, required 0", global_predicton_taken);
        else passed++;
        resolve(1'b0);
        checks++;
        if (resolve_ready !== 1'b0)
            $display("FAIL train_drain: resolve_ready=%b, required 0", resolve_ready);
        else passed++;
    endtask

    task automatic test_queue_full();
        int accepted;
        accepted = 0;
        pred_valid = 1'b1;
        pred_pc    = 32'h0000_3000;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pred_out_valid === 1'b1) accepted++;
        end
        checks++;
        if (accepted !== 8) $display("FAIL b2b_accept: accepted=%0d, required 8", accepted);
        else passed++;
        checks++;
        if (pred_ready !== 1'b0) $display("FAIL full_rdy: pred_ready=%b, required 0", pred_ready);
        else passed++;
        tick();
        checks++;
        if (pred_out_valid !== 1'b0)
            $display("FAIL full_9th: pred_out_valid=%b, required 0", pred_out_valid);
        else passed++;
        // Pop while full: the held request is still refused this cycle.
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        tick();
        resolve_valid = 1'b0;
        pred_valid    = 1'b0;
        checks++;
        if (pred_out_valid !== 1'b0 || pred_ready !== 1'b1)
            $display("FAIL full_pop: pov=%b pred_ready=%b, required 0 1",
                     pred_out_valid, pred_ready);
        else passed++;
        for (int i = 0; i < 7; i++) resolve(1'b0);
        checks++;
        if (resolve_ready !== 1'b0)
            $display("FAIL full_drain: resolve_ready=%b, required 0", resolve_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_init();
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        // Fresh sweep, then interrupt it at cycle 2000.
        for (int i = 0; i < 2000; i++) tick();
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid_init_reset");
        check_init_len("mid_init");
    endtask

    task automatic test_same_cycle();
        logic exp_fwd;
`ifdef GSHARE_FWD_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        predict(32'h0000_1000);
        // Resolve pops 0x400 (01 -> 10) while predicting 0x400 with pre-shift GHR.
        pred_valid    = 1'b1;
        pred_pc       = 32'h0000_1000;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        pred_valid    = 1'b0;
        resolve_valid = 1'b0;
        checks++;
        if (pred_out_valid !== 1'b1 || global_predicton_taken !== exp_fwd)
            $display("FAIL same_cycle: pov=%b taken=%b, required 1 %b",
                     pred_out_valid, global_predicton_taken, exp_fwd);
        else passed++;
        // GHR = 1; PC bits 0x401 map to 0x400, now holding 10.
        predict(32'h0000_1004);
        checks++;
        if (global_predicton_taken !== 1'b1)
            $display("FAIL same_stored: taken=%b, required 1", global_predicton_taken);
        else passed++;
        predict(32'h0000_2000);
    endtask

    task automatic test_reset_mid_run();
        checks++;
        if (resolve_ready !== 1'b1 || pred_out_valid !== 1'b1)
            $display("FAIL run_pending: rrdy=%b pov=%b, required 1 1",
                     resolve_ready, pred_out_valid);
        else passed++;
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid_run_reset");
        check_init_len("mid_run");
        checks++;
        if (resolve_ready !== 1'b0)
            $display("FAIL run_queue: resolve_ready=%b, required 0", resolve_ready);
        else passed++;
        // Entry 0x400 held 10 before reset; sweep must restore 01.
        predict(32'h0000_1000);
        checks++;
        if (pred_out_valid !== 1'b1 || global_predicton_taken !== 1'b0)
            $display("FAIL run_reinit: pov=%b taken=%b, required 1 0",
                     pred_out_valid, global_predicton_taken);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_first_predict();
        test_training();
        test_queue_full();
        test_reset_mid_init();
        test_same_cycle();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gshare_global_predictor.md
# gshare_global_predictor

- Global-history branch direction predictor; its output drives `global_predicton_taken` on the tournament top level.
- Prediction index = PC bits XOR its own non-speculative 12-bit global history register. The index selects one entry in a table of 2-bit saturating counters.
- Each prediction's index is held in an in-order pending queue. When the branch resolves, that exact counter is trained, even if history has moved since.
- Initialises the whole table after reset with a sweep FSM.

## Interface
Parameters:
- `GHR_W`, 12, history width; table has 2^GHR_W counters
- `PC_LSB`, 2, lowest PC bit used in the index
- `Q_DEPTH`, 8, pending-queue entries (power of two)

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low; asserting low clears state immediately
- `pred_valid`  in  1  prediction request
- `pred_pc`  in  32  branch PC
- `pred_ready`  out  1  request accepted when `pred_valid & pred_ready`
- `pred_out_valid`  out  1  prediction result valid
- `global_predicton_taken`  out  1  predicted direction
- `resolve_valid`  in  1  oldest pending branch resolved
- `resolve_taken`  in  1  actual outcome
- `resolve_ready`  out  1  = queue not empty
- `init_done`  out  1  table sweep complete

## Operation
- FSM states:
  - INIT: entered on reset. A counter walks entries 0..2^GHR_W-1, writing 2'b01 (weakly not-taken) one per cycle. Goes to RUN after the last write.
  - RUN: normal operation.
- `pred_ready` = RUN & queue not full.
- On an accepted prediction:
  - index = `pred_pc[PC_LSB+GHR_W-1:PC_LSB]` ^ GHR.
  - Counter read; prediction = counter[1].
  - Index pushed to the queue.
- On an accepted resolve:
  - Pop the oldest index.
  - Counter updated: +1 if taken, saturating at 3; -1 if not taken, saturating at 0.
  - GHR <= {GHR[GHR_W-2:0], resolve_taken}.
- Resolves arrive in program order. `resolve_valid` with an empty queue is ignored; no state change.
- Simultaneous predict and resolve:
  - The prediction index uses the pre-shift GHR.
  - Push and pop both occur, so occupancy is unchanged.
  - `pred_ready` is still computed from current fullness. A full queue stays non-accepting that cycle, even while popping.
- Same-entry read and write in one cycle: behaviour is set by the Configuration macro.

## Timing
- Reset values:
  - `pred_ready`=0, `pred_out_valid`=0, `global_predicton_taken`=0, `resolve_ready`=0, `init_done`=0.
  - GHR=0, queue pointers=0, FSM=INIT, sweep counter=0.
- INIT lasts exactly 2^GHR_W cycles after reset deassertion. `init_done` and `pred_ready` rise on the next cycle.
- Prediction latency is 1 cycle. A request accepted at edge N gives `pred_out_valid`=1 with the registered result during cycle N+1. `pred_out_valid` is low otherwise.
- Resolve:
  - Counter write and GHR shift take effect at the accepting edge.
  - A prediction accepted at edge N+1 sees the updated GHR and counter.
- Reset asserted mid-INIT or mid-RUN:
  - The queue is discarded and outstanding predictions are lost.
  - The sweep restarts from entry 0.

## Configuration
- `GSHARE_FWD_EN` defined: when a same-cycle resolve writes the entry being read, the prediction uses the post-update counter.
- Not defined: the prediction uses the pre-update (stored) counter.
- No other behaviour differs.

## Structure
- Shared package `gshare_pkg` holds:
  - `ctr2_t` (2-bit counter typedef)
  - constants `CTR_WEAK_NT`=2'b01 and `CTR_MAX`=2'b11
  - FSM enum `gshare_state_e` {INIT, RUN}
- Sub-module `gshare_pending_fifo` holds the pending indices:
  - GHR_W-bit entries, Q_DEPTH deep
  - full/empty from pointers with a wrap bit
  - push and pop in the same cycle allowed
- Counter table and FSM live in the top module.

## Test plan
- Reset, release: `pred_ready`=0 for 4096 cycles, 1 on cycle 4097; `init_done` rises with it.
- After init, predict PC 0x0000_1000: one cycle later `pred_out_valid`=1, `global_predicton_taken`=0.
- Training:
  - 12 taken resolves of PC 0x1000 (each preceded by a prediction) fill GHR to 0xFFF.
  - Two more predict/resolve(taken) pairs take the counter at index 0x400^0xFFF from 01 to 11.
  - Next prediction = 1; three not-taken resolves bring it back to 0.
- Queue full: 8 predictions with no resolves give `pred_ready`=0. The 9th `pred_valid` is not accepted. One resolve gives `pred_ready`=1 next cycle.
- Same cycle, same index, counter=01, resolve taken: prediction = 1 with `GSHARE_FWD_EN`, 0 without. Stored counter = 10 in both builds.
- Reset asserted at INIT cycle 2000 and again during RUN with 3 pending:
  - Outputs go to reset values immediately.
  - The sweep restarts and takes a full 4096 cycles.
  - `resolve_ready`=0 afterwards.
